// File: rtl/viterbi_pkg.sv
// Shared definitions for the rate-1/2 K=3 convolutional encoder/framer.
// Latency: n/a (types, constants and a parity helper only).
// Backpressure: n/a.
package viterbi_pkg;

  localparam int           K         = 3;
  localparam int           PAIRS_DEF = 7;
  localparam logic [K-1:0] G0_DEF    = 3'b111;
  localparam logic [K-1:0] G1_DEF    = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic parity(input logic [K-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/conv_enc_framer_if.sv
// Info-bit input handshake and serial coded-bit output of the framer.
// Latency: n/a (wiring only).
// Backpressure: din_valid/din_ready on the input; the output has none (fixed-rate stream).
// master: info-bit source and coded-bit sink; slave: the framer itself.
interface conv_enc_framer_if;

  logic din;
  logic din_valid;
  logic din_ready;
  logic x;
  logic x_valid;
  logic frame_start;
  logic err_gap;

  modport master (
    output din, din_valid,
    input  din_ready, x, x_valid, frame_start, err_gap
  );

  modport slave (
    input  din, din_valid,
    output din_ready, x, x_valid, frame_start, err_gap
  );

endinterface

// File: rtl/conv_enc_core.sv
// K=3 convolutional encoder kernel: selects generator G0/G1, holds {s1,s0}.
// Latency: coded bit is combinational from u and the stored state; state updates on step.
// Backpressure: none; the caller strobes step once per coded pair.
// Ports: clk, rst (async, active-high); u info bit; sel 0=G0 1=G1;
//        step shifts u into the state; clr forces the state to 00 for this cycle and onward.
module conv_enc_core
  import viterbi_pkg::*;
#(
  parameter logic [K-1:0] G0 = G0_DEF,
  parameter logic [K-1:0] G1 = G1_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic u,
  input  logic sel,
  input  logic step,
  input  logic clr,
  output logic coded
);

  // s_q = {s1, s0}
  logic [1:0] s_q, s_d, s_eff;

  always_comb begin
    // clr takes effect on the bit being computed, not just the next one,
    // so the first bit of a terminated frame already sees state 00.
    s_eff = clr ? 2'b00 : s_q;
    coded = parity((sel ? G1 : G0) & {u, s_eff[0], s_eff[1]});
    s_d   = step ? {s_eff[0], u} : s_eff;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_q <= 2'b00;
    else     s_q <= s_d;
  end

endmodule

// File: rtl/conv_enc_framer.sv
// Collects info bits, encodes them rate-1/2 K=3 and emits 2*PAIRS-bit frames back to back.
// Latency: first coded bit one cycle after the transfer cycle; x/x_valid/frame_start registered.
// Backpressure: din_ready drops once a full frame of info bits is buffered, until it is transferred.
// Ports: clk, rst (async, active-high); bus (slave): din/din_valid/din_ready in,
//        x/x_valid/frame_start/err_gap out.
// Build option ZERO_TAIL_EN: PAIRS-2 info bits plus 2 zero tail bits, state cleared per frame.
module conv_enc_framer
  import viterbi_pkg::*;
#(
  parameter int           PAIRS = PAIRS_DEF,
  parameter logic [K-1:0] G0    = G0_DEF,
  parameter logic [K-1:0] G1    = G1_DEF
) (
  input  logic             clk,
  input  logic             rst,
  conv_enc_framer_if.slave bus
);

`ifdef ZERO_TAIL_EN
  localparam int   NINFO = PAIRS - 2;
  localparam logic ZT    = 1'b1;
`else
  localparam int   NINFO = PAIRS;
  localparam logic ZT    = 1'b0;
`endif

  localparam int              ICW     = $clog2(NINFO + 1);
  localparam int              BCW     = $clog2(2 * PAIRS);
  localparam logic [ICW-1:0]  IC_FULL = ICW'(NINFO);
  localparam logic [BCW-1:0]  BC_LAST = BCW'(2 * PAIRS - 1);
  localparam logic [BCW-1:0]  NINFO_B = BCW'(NINFO);

  state_t           state_q, state_d;
  logic [ICW-1:0]   ic_q, ic_d;
  logic [BCW-1:0]   bc_q, bc_d;
  logic [NINFO-1:0] info_q, info_d;
  logic [NINFO-1:0] frm_q, frm_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             fs_q, fs_d;
  logic             err_q, err_d;

  logic           last, transfer, accept, emit, u, coded;
  logic [BCW-1:0] nb;

  // Select the bit that goes out next cycle: bit 0 of the new frame on a
  // transfer, otherwise the successor of the bit currently on x.
  always_comb begin
    last     = (state_q == RUN) && (bc_q == BC_LAST);
    transfer = (ic_q == IC_FULL) && ((state_q == IDLE) || last);
    accept   = bus.din_valid && (ic_q != IC_FULL);
    emit     = 1'b0;
    nb       = '0;
    u        = 1'b0;
    if (transfer) begin
      emit = 1'b1;
      u    = info_q[0];
    end else if ((state_q == RUN) && !last) begin
      emit = 1'b1;
      nb   = bc_q + BCW'(1);
      // Pairs past the info bits are the zero tail.
      if ({1'b0, nb[BCW-1:1]} < NINFO_B) u = frm_q[nb[BCW-1:1]];
    end
  end

  conv_enc_core #(.G0(G0), .G1(G1)) u_core (
    .clk   (clk),
    .rst   (rst),
    .u     (u),
    .sel   (nb[0]),
    .step  (emit & nb[0]),
    .clr   (transfer & ZT),
    .coded (coded)
  );

  always_comb begin
    state_d   = state_q;
    ic_d      = ic_q;
    bc_d      = bc_q;
    info_d    = info_q;
    frm_d     = frm_q;
    err_d     = err_q;
    x_d       = emit & coded;
    x_valid_d = emit;
    fs_d      = transfer;
    if (accept) begin
      // First accepted bit ends up in bit 0, which is encoded first.
      info_d = {bus.din, info_q[NINFO-1:1]};
      ic_d   = ic_q + ICW'(1);
    end
    if (transfer) begin
      frm_d   = info_q;
      ic_d    = '0;
      bc_d    = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      if (last) begin
        state_d = IDLE;
        bc_d    = '0;
        err_d   = 1'b1;
      end else begin
        bc_d = nb;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ic_q      <= '0;
      bc_q      <= '0;
      info_q    <= '0;
      frm_q     <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      fs_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ic_q      <= ic_d;
      bc_q      <= bc_d;
      info_q    <= info_d;
      frm_q     <= frm_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      fs_q      <= fs_d;
      err_q     <= err_d;
    end
  end

  assign bus.din_ready   = (ic_q != IC_FULL);
  assign bus.x           = x_q;
  assign bus.x_valid     = x_valid_q;
  assign bus.frame_start = fs_q;
  assign bus.err_gap     = err_q;

endmodule
